// File: rtl/if_id_pipeline.sv
// ---------------------------------------------------------------------------
// if_id_pipeline
//
// Fetch side of the 5-stage RISC-V pipeline. This module holds the program
// counter and the IF/ID pipeline register. It acts on the hazard unit's
// pc_load / if_id_load / mux5_selector decisions and on branch redirects
// resolved in EX. It also generates the registered ID/EX bubble and keeps
// saturating debug counters for stall and flush cycles.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high reset (wins over all inputs)
//   pc_load        1 = PC may advance by PC_STEP
//   if_id_load     1 = IF/ID captures {pc, imem_instr}
//   mux5_selector  1 = force ID/EX control to zero next cycle
//   branch_taken   EX resolved a taken branch this cycle
//   branch_target  redirect address (low two bits ignored)
//   imem_instr     instruction read combinationally at pc
//   pc             current fetch address
//   if_id_pc       PC of the instruction held in IF/ID
//   if_id_instr    instruction held in IF/ID
//   if_id_valid    1 = IF/ID holds a real instruction
//   id_ex_bubble   registered bubble request for ID/EX
//   stall_count    saturating count of stall cycles
//   flush_count    saturating count of redirects
//   state          0 RUN, 1 STALL, 2 FLUSH
// ---------------------------------------------------------------------------
module if_id_pipeline #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4,
  parameter logic [31:0] NOP      = 32'h0000_0013,
  parameter int          CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pc_load,
  input  logic             if_id_load,
  input  logic             mux5_selector,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      if_id_pc_reg, if_id_pc_next;
  logic [31:0]      if_id_instr_reg, if_id_instr_next;
  logic             if_id_valid_reg, if_id_valid_next;
  logic             bubble_reg, bubble_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;

  // Instructions are word aligned, so the low target bits are discarded.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  // Stall cycles exclude redirect cycles: a redirect flushes IF/ID
  // regardless of if_id_load, so that cycle is accounted as a flush.
  logic stall_event;
  assign stall_event = !if_id_load && !branch_taken;

  // -------------------------------------------------------------------------
  // PC and IF/ID next values. A redirect has priority over the hazard
  // unit's load enables, because the instructions behind a taken branch
  // are on the wrong path and must not be kept.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_next = pc_reg;
    if (branch_taken) begin
      pc_next = {branch_target[31:2], 2'b00};
    end else if (pc_load) begin
      pc_next = pc_reg + 32'(PC_STEP);  // wraps modulo 2^32
    end
  end

  always_comb begin
    if_id_pc_next    = if_id_pc_reg;
    if_id_instr_next = if_id_instr_reg;
    if_id_valid_next = if_id_valid_reg;
    if (branch_taken) begin
      if_id_pc_next    = 32'h0000_0000;
      if_id_instr_next = NOP;
      if_id_valid_next = 1'b0;
    end else if (if_id_load) begin
      if_id_pc_next    = pc_reg;
      if_id_instr_next = imem_instr;
      if_id_valid_next = 1'b1;
    end
  end

  // Bubble is registered so that ID/EX sees no combinational path from
  // the hazard unit or from EX.
  assign bubble_next = mux5_selector | branch_taken;

  // -------------------------------------------------------------------------
  // Saturating debug counters.
  // -------------------------------------------------------------------------
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    if (stall_event && (stall_cnt_reg != CNT_MAX)) begin
      stall_cnt_next = stall_cnt_reg + 1'b1;
    end
    if (branch_taken && (flush_cnt_reg != CNT_MAX)) begin
      flush_cnt_next = flush_cnt_reg + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Status FSM. It is recomputed from the current inputs on every edge and
  // has no sticky states. It reports what the fetch side did on the
  // last edge.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = ST_RUN;
    if (branch_taken) begin
      state_next = ST_FLUSH;
    end else if (!if_id_load) begin
      state_next = ST_STALL;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_reg          <= RESET_PC;
      if_id_pc_reg    <= 32'h0000_0000;
      if_id_instr_reg <= NOP;
      if_id_valid_reg <= 1'b0;
      bubble_reg      <= 1'b1;
      stall_cnt_reg   <= '0;
      flush_cnt_reg   <= '0;
    end else begin
      pc_reg          <= pc_next;
      if_id_pc_reg    <= if_id_pc_next;
      if_id_instr_reg <= if_id_instr_next;
      if_id_valid_reg <= if_id_valid_next;
      bubble_reg      <= bubble_next;
      stall_cnt_reg   <= stall_cnt_next;
      flush_cnt_reg   <= flush_cnt_next;
    end
  end

  assign pc           = pc_reg;
  assign if_id_pc     = if_id_pc_reg;
  assign if_id_instr  = if_id_instr_reg;
  assign if_id_valid  = if_id_valid_reg;
  assign id_ex_bubble = bubble_reg;
  assign stall_count  = stall_cnt_reg;
  assign flush_count  = flush_cnt_reg;
  assign state        = state_reg;

endmodule
